// File: rtl/mem_scan_pkg.sv
// +------------------------------------------------------------------+
// | mem_scan_pkg: shared types and defaults for the memory scan reader |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mem_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } scan_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

endpackage

`default_nettype wire

// File: rtl/mem_scan_array.sv
// +------------------------------------------------------------------+
// | mem_scan_array: DEPTH x DATA_WIDTH storage, one write port and    |
// | one enable-gated synchronous read port; contents are not reset.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mem_scan_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read samples the pre-write contents, so a same-row write in this cycle is not seen.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < C_DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/mem_scan_reader.sv
// +------------------------------------------------------------------+
// | mem_scan_reader: scans a wrapping row range and streams each word |
// | over valid/ready. Trace build: define MEM_SCAN_READER_TRACE_EN.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mem_scan_reader
  import mem_scan_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ROW = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   C_ONE_LEN  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ONE_ADDR = ADDR_WIDTH'(1);

  scan_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  done_q, done_d;
  logic                  rd_en;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] rd_data;

  assign rd_en     = (state_q == FETCH);
  assign handshake = (state_q == HOLD) && out_ready;

  mem_scan_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en && !rst),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    out_addr_d = out_addr_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            // DEPTH need not be a power of two, so fold the base explicitly.
            addr_d   = ADDR_WIDTH'(32'(base_addr) % 32'(DEPTH));
            remain_d = length;
            state_d  = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        out_addr_d = addr_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (remain_q == C_ONE_LEN) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            remain_d = remain_q - C_ONE_LEN;
            addr_d   = (addr_q == C_LAST_ROW) ? '0 : addr_q + C_ONE_ADDR;
            state_d  = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      out_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      out_addr_q <= out_addr_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_valid ? rd_data : '0;
  assign out_addr  = out_addr_q;
  assign done      = done_q;

`ifdef MEM_SCAN_READER_TRACE_EN
  logic                  trace_pend_q;
  logic [DATA_WIDTH-1:0] trace_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_pend_q <= 1'b0;
      trace_data_q <= '0;
    end else begin
      if (trace_pend_q && !(out_valid && (out_data == trace_data_q))) begin
        $error("hold violated");
      end
      if (handshake) begin
        $display("scan addr=%0d data=%0h", out_addr, out_data);
      end
      trace_pend_q <= out_valid && !out_ready;
      trace_data_q <= out_data;
    end
  end
`endif

endmodule

`default_nettype wire
